// File: rtl/iic_fifo_serializer.sv
// iic_fifo_serializer
// Pops 16-bit words from the head of a FIFO and shifts them out MSB-first on a
// 3-wire serial link (bit clock, data, frame sync). The bit rate comes from a
// programmable half-period divider that is latched at each word load.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   en_i            streaming enable
//   div_i           bit-clock half-period in clk_i cycles, minus 1
//   fifo_outdata_i  FIFO head word, valid while fifo_empty_i=0
//   fifo_empty_i    FIFO empty flag
//   fifo_rd_o       one-cycle pulse advancing the FIFO read pointer
//   ser_clk_o       serial bit clock, idles low
//   ser_data_o      serial data, updated on ser_clk_o falling edges
//   ser_frame_o     high during the MSB bit period of every word
//   busy_o          a word is being shifted
//   underrun_o      sticky underrun flag, cleared by en_i=0
//
// State | Meaning
// ------+------------------------------------------------------------
// IDLE  | link quiet, waiting for en_i=1 with a non-empty FIFO
// SHIFT | a word is on the wire; the divider paces ser_clk_o toggles

module iic_fifo_serializer #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [15:0]      fifo_outdata_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    output logic             ser_clk_o,
    output logic             ser_data_o,
    output logic             ser_frame_o,
    output logic             busy_o,
    output logic             underrun_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [15:0]      shreg;
    logic [3:0]       bitcnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] divcnt;

    logic       load_ok;
    logic       div_tc;
    logic       word_end;
    logic       do_load;
    logic [3:0] bit_nxt;

    assign load_ok  = en_i & ~fifo_empty_i;
    assign div_tc   = (divcnt == div_q);
    // Last falling toggle of the word: the LSB period is over.
    assign word_end = (state == ST_SHIFT) && div_tc && ser_clk_o && (bitcnt == 4'd0);
    // A load happens from IDLE or directly at the end of a word, so that
    // back-to-back words stream with no idle bit clock in between.
    assign do_load  = load_ok && ((state == ST_IDLE) || word_end);
    assign bit_nxt  = bitcnt - 4'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            div_q       <= '0;
            divcnt      <= '0;
            fifo_rd_o   <= 1'b0;
            ser_clk_o   <= 1'b0;
            ser_data_o  <= 1'b0;
            ser_frame_o <= 1'b0;
            busy_o      <= 1'b0;
            underrun_o  <= 1'b0;
        end else begin
            fifo_rd_o <= 1'b0;
            if (!en_i) begin
                underrun_o <= 1'b0;
            end

            if (do_load) begin
                shreg       <= fifo_outdata_i;
                div_q       <= div_i;
                fifo_rd_o   <= 1'b1;
                ser_data_o  <= fifo_outdata_i[15];
                ser_frame_o <= 1'b1;
                ser_clk_o   <= 1'b0;
                bitcnt      <= 4'd15;
                divcnt      <= '0;
                busy_o      <= 1'b1;
                state       <= ST_SHIFT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ser_clk_o   <= 1'b0;
                        ser_data_o  <= 1'b0;
                        ser_frame_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                    ST_SHIFT: begin
                        if (!div_tc) begin
                            divcnt <= divcnt + DIV_W'(1);
                        end else begin
                            divcnt    <= '0;
                            ser_clk_o <= ~ser_clk_o;
                            if (ser_clk_o) begin
                                if (bitcnt != 4'd0) begin
                                    bitcnt      <= bit_nxt;
                                    ser_data_o  <= shreg[bit_nxt];
                                    ser_frame_o <= 1'b0;
                                end else begin
                                    // Word finished and no next word taken.
                                    state       <= ST_IDLE;
                                    busy_o      <= 1'b0;
                                    ser_data_o  <= 1'b0;
                                    ser_frame_o <= 1'b0;
                                    if (en_i) begin
                                        underrun_o <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_fifo_serializer.sv
module tb_iic_fifo_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  div = 8'd0;
    logic [15:0] fifo_outdata;
    logic        fifo_empty;
    logic        fifo_rd_o, ser_clk_o, ser_data_o, ser_frame_o, busy_o, underrun_o;

    int tests = 0;
    int fails = 0;

    // Small FIFO model feeding the DUT
    logic [15:0] mem [0:7];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int rd_count = 0;
    int rd_while_empty = 0;
    int cyc = 0;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_outdata = mem[rd_ptr[2:0]];

    // Capture state
    logic [63:0] cap_data;
    logic [63:0] cap_frame;
    int          cap_n;
    int          rise_cyc [0:63];
    int          busy_low;
    logic        prev_sclk;
    int          t0;
    int          rd0;

    iic_fifo_serializer #(.DIV_W(8)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .en_i           (en),
        .div_i          (div),
        .fifo_outdata_i (fifo_outdata),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_o      (fifo_rd_o),
        .ser_clk_o      (ser_clk_o),
        .ser_data_o     (ser_data_o),
        .ser_frame_o    (ser_frame_o),
        .busy_o         (busy_o),
        .underrun_o     (underrun_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_o) begin
            rd_count++;
            if (fifo_empty) rd_while_empty++;
            else rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [15:0] w);
        mem[wr_ptr[2:0]] = w;
        wr_ptr++;
    endtask

    task automatic clear_capture();
        cap_data  = '0;
        cap_frame = '0;
        cap_n     = 0;
        busy_low  = 0;
        prev_sclk = ser_clk_o;
        t0        = cyc;
        rd0       = rd_count;
    endtask

    // Advance n cycles, sampling at each falling clk edge; record data/frame
    // and the cycle number at every ser_clk_o rising edge.
    task automatic step_capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!busy_o) busy_low++;
            if (ser_clk_o && !prev_sclk) begin
                cap_data  = {cap_data[62:0], ser_data_o};
                cap_frame = {cap_frame[62:0], ser_frame_o};
                if (cap_n < 64) rise_cyc[cap_n] = cyc;
                cap_n++;
            end
            prev_sclk = ser_clk_o;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({fifo_rd_o, ser_clk_o, ser_data_o, ser_frame_o, busy_o, underrun_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {fifo_rd_o, ser_clk_o, ser_data_o, ser_frame_o, busy_o, underrun_o});
        end
        rst_n = 1'b1;
        step_capture(2);
        tests++;
        if ({fifo_rd_o, busy_o} !== 2'b00) begin
            fails++; $display("FAIL idle_empty: rd/busy got %b expected 00", {fifo_rd_o, busy_o});
        end
    endtask

    task automatic test_single();
        div = 8'd0;
        push(16'hA5C3);
        clear_capture();
        en = 1'b1;
        step_capture(1);
        tests++;
        if ({fifo_rd_o, ser_frame_o, busy_o, ser_clk_o} !== 4'b1110) begin
            fails++; $display("FAIL single_load: rd/frame/busy/sclk got %b expected 1110",
                              {fifo_rd_o, ser_frame_o, busy_o, ser_clk_o});
        end
        step_capture(1);
        tests++;
        if (fifo_rd_o !== 1'b0) begin
            fails++; $display("FAIL single_rd_pulse_width: got %b expected 0", fifo_rd_o);
        end
        step_capture(30);
        tests++;
        if (busy_o !== 1'b1) begin
            fails++; $display("FAIL single_busy_31: got %b expected 1", busy_o);
        end
        step_capture(1);
        tests++;
        if ({busy_o, underrun_o} !== 2'b01) begin
            fails++; $display("FAIL single_end: busy/underrun got %b expected 01", {busy_o, underrun_o});
        end
        tests++;
        if (cap_n !== 16 || cap_data[15:0] !== 16'hA5C3) begin
            fails++; $display("FAIL single_data: got %0d bits %h expected 16 bits a5c3", cap_n, cap_data[15:0]);
        end
        tests++;
        if (cap_frame[15:0] !== 16'h8000) begin
            fails++; $display("FAIL single_frame: got %h expected 8000", cap_frame[15:0]);
        end
        tests++;
        if (rise_cyc[0] - t0 !== 2) begin
            fails++; $display("FAIL single_first_rise: got %0d expected 2", rise_cyc[0] - t0);
        end
        tests++;
        if (rd_count - rd0 !== 1) begin
            fails++; $display("FAIL single_rd_count: got %0d expected 1", rd_count - rd0);
        end
    endtask

    task automatic test_underrun_clear();
        en = 1'b0;
        step_capture(1);
        tests++;
        if (underrun_o !== 1'b0) begin
            fails++; $display("FAIL underrun_clear: got %b expected 0", underrun_o);
        end
        push(16'h1234);
        clear_capture();
        en = 1'b1;
        step_capture(1);
        tests++;
        if ({busy_o, ser_frame_o, underrun_o} !== 3'b110) begin
            fails++; $display("FAIL restart_load: busy/frame/underrun got %b expected 110",
                              {busy_o, ser_frame_o, underrun_o});
        end
        step_capture(32);
        tests++;
        if (busy_o !== 1'b0 || cap_data[15:0] !== 16'h1234 || underrun_o !== 1'b1) begin
            fails++; $display("FAIL restart_word: busy %b data %h underrun %b expected 0 1234 1",
                              busy_o, cap_data[15:0], underrun_o);
        end
        en = 1'b0;
        step_capture(2);
    endtask

    task automatic test_back_to_back();
        div = 8'd3;
        push(16'h8001);
        push(16'h7FFE);
        clear_capture();
        en = 1'b1;
        step_capture(256);
        tests++;
        if (busy_low !== 0 || busy_o !== 1'b1) begin
            fails++; $display("FAIL b2b_busy_gap: low samples %0d busy %b expected 0 1", busy_low, busy_o);
        end
        step_capture(1);
        tests++;
        if (busy_o !== 1'b0 || underrun_o !== 1'b1) begin
            fails++; $display("FAIL b2b_end: busy/underrun got %b expected 01", {busy_o, underrun_o});
        end
        tests++;
        if (cap_n !== 32 || cap_data[31:0] !== 32'h80017FFE) begin
            fails++; $display("FAIL b2b_data: got %0d bits %h expected 32 bits 80017ffe", cap_n, cap_data[31:0]);
        end
        tests++;
        if (cap_frame[31:0] !== 32'h80008000) begin
            fails++; $display("FAIL b2b_frame: got %h expected 80008000", cap_frame[31:0]);
        end
        tests++;
        if (rd_count - rd0 !== 2) begin
            fails++; $display("FAIL b2b_rd_count: got %0d expected 2", rd_count - rd0);
        end
        tests++;
        if (rise_cyc[0] - t0 !== 5 || rise_cyc[16] - t0 !== 133) begin
            fails++; $display("FAIL b2b_rise_times: got %0d %0d expected 5 133",
                              rise_cyc[0] - t0, rise_cyc[16] - t0);
        end
        tests++;
        if (rise_cyc[16] - rise_cyc[15] !== 8) begin
            fails++; $display("FAIL b2b_seamless: got %0d expected 8", rise_cyc[16] - rise_cyc[15]);
        end
        en = 1'b0;
        step_capture(2);
    endtask

    task automatic test_graceful_disable();
        div = 8'd1;
        push(16'hFFFF);
        push(16'h1111);
        clear_capture();
        en = 1'b1;
        step_capture(20);
        en = 1'b0;
        step_capture(44);
        tests++;
        if (busy_o !== 1'b1) begin
            fails++; $display("FAIL disable_no_truncate: busy got %b expected 1", busy_o);
        end
        step_capture(1);
        tests++;
        if (busy_o !== 1'b0 || underrun_o !== 1'b0) begin
            fails++; $display("FAIL disable_end: busy/underrun got %b expected 00", {busy_o, underrun_o});
        end
        tests++;
        if (cap_n !== 16 || cap_data[15:0] !== 16'hFFFF) begin
            fails++; $display("FAIL disable_data: got %0d bits %h expected 16 bits ffff", cap_n, cap_data[15:0]);
        end
        step_capture(10);
        tests++;
        if (rd_count - rd0 !== 1 || busy_o !== 1'b0 || ser_data_o !== 1'b0) begin
            fails++; $display("FAIL disable_idle: rd %0d busy %b data %b expected 1 0 0",
                              rd_count - rd0, busy_o, ser_data_o);
        end
        wr_ptr = rd_ptr;
    endtask

    task automatic test_div_latch();
        div = 8'd1;
        push(16'h0F0F);
        push(16'h3333);
        clear_capture();
        en = 1'b1;
        step_capture(10);
        div = 8'd7;
        step_capture(310);
        tests++;
        if (busy_o !== 1'b1) begin
            fails++; $display("FAIL latch_busy: got %b expected 1", busy_o);
        end
        step_capture(1);
        tests++;
        if (busy_o !== 1'b0 || cap_n !== 32 || cap_data[31:0] !== 32'h0F0F3333) begin
            fails++; $display("FAIL latch_data: busy %b bits %0d data %h expected 0 32 0f0f3333",
                              busy_o, cap_n, cap_data[31:0]);
        end
        tests++;
        if (rise_cyc[1] - rise_cyc[0] !== 4 || rise_cyc[15] - rise_cyc[14] !== 4) begin
            fails++; $display("FAIL latch_period_word1: got %0d %0d expected 4 4",
                              rise_cyc[1] - rise_cyc[0], rise_cyc[15] - rise_cyc[14]);
        end
        tests++;
        if (rise_cyc[17] - rise_cyc[16] !== 16 || rise_cyc[16] - t0 !== 73) begin
            fails++; $display("FAIL latch_period_word2: got %0d %0d expected 16 73",
                              rise_cyc[17] - rise_cyc[16], rise_cyc[16] - t0);
        end
        en = 1'b0;
        div = 8'd1;
        step_capture(2);
    endtask

    task automatic test_reset_midword();
        div = 8'd1;
        push(16'hABCD);
        push(16'h5555);
        clear_capture();
        en = 1'b1;
        step_capture(34);
        tests++;
        if (busy_o !== 1'b1) begin
            fails++; $display("FAIL midword_busy: got %b expected 1", busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({fifo_rd_o, ser_clk_o, ser_data_o, ser_frame_o, busy_o, underrun_o} !== 6'b0) begin
            fails++; $display("FAIL async_reset: got %b expected 000000",
                              {fifo_rd_o, ser_clk_o, ser_data_o, ser_frame_o, busy_o, underrun_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_capture();
        step_capture(1);
        tests++;
        if ({fifo_rd_o, ser_frame_o, busy_o} !== 3'b111) begin
            fails++; $display("FAIL post_reset_load: rd/frame/busy got %b expected 111",
                              {fifo_rd_o, ser_frame_o, busy_o});
        end
        step_capture(64);
        tests++;
        if (busy_o !== 1'b0 || cap_n !== 16 || cap_data[15:0] !== 16'h5555 || rd_count - rd0 !== 1) begin
            fails++; $display("FAIL post_reset_word: busy %b bits %0d data %h rd %0d expected 0 16 5555 1",
                              busy_o, cap_n, cap_data[15:0], rd_count - rd0);
        end
        en = 1'b0;
        step_capture(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_underrun_clear();
        test_back_to_back();
        test_graceful_disable();
        test_div_latch();
        test_reset_midword();
        tests++;
        if (rd_while_empty !== 0) begin
            fails++; $display("FAIL rd_while_empty: got %0d expected 0", rd_while_empty);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
